// File: rtl/key_event_pkg.sv
// key_event_pkg
// Shared types and helpers for the key event generator.
//   key_fsm_e  : per-key debounce / repeat state
//   KEY_IDX_W  : width of the event code (supports up to 8 keys)
//   cnt_width(): tick-counter width, sized from the largest tick parameter
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    REPEATING = 3'd3,
    DEB_REL   = 3'd4
  } key_fsm_e;

  localparam int KEY_IDX_W = 3;

  // One spare bit above clog2(max) so the saturating counter never has to
  // stop short of any terminal-count value.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) m = 2;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_event_fsm.sv
// key_event_fsm
// Debounce and auto-repeat state machine for a single synchronised key.
// All outputs are registered; the *_set outputs expose the values that will
// be loaded into the pulse registers on the next edge so the top level can
// build an event code aligned with the pulses.
//
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_key_s            synchronised key, 0 = pressed
//   i_tick             shared timebase strobe, one clk wide
//   o_key_state        debounced level, 0 = pressed
//   o_press_pulse      one-clk pulse on accepted press
//   o_release_pulse    one-clk pulse on accepted release
//   o_repeat_pulse     one-clk pulse per auto-repeat
//   o_press_set        press pulse to be registered this edge
//   o_repeat_set       repeat pulse to be registered this edge
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | key released and accepted as released, no counting
// DEB_PRESS | key_s low, counting ticks before accepting the press
// HELD      | press accepted, counting ticks towards the first repeat
// REPEATING | repeating, counting ticks between repeat pulses
// DEB_REL   | key_s high while pressed, counting ticks before release
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_TICKS     = 20,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_s,
  input  logic i_tick,
  output logic o_key_state,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_repeat_pulse,
  output logic o_press_set,
  output logic o_repeat_set
);

  localparam int CNT_W = cnt_width(DEBOUNCE_TICKS, REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  key_fsm_e          r_state;
  key_fsm_e          w_state_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CNT_W-1:0]  w_count_inc;
  logic              r_key_state;
  logic              r_press;
  logic              r_release;
  logic              r_repeat;
  logic              w_press_nxt;
  logic              w_release_nxt;
  logic              w_repeat_nxt;
  logic              w_key_state_nxt;

  // Saturating increment: a count never wraps back to zero.
  assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);

  // A key_s change always takes priority over a tick on the same clk, so the
  // tick is only looked at in the else branch of each state.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_repeat_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_key_s) begin
          w_state_nxt = DEB_PRESS;
          w_count_nxt = '0;
        end
      end
      DEB_PRESS: begin
        if (i_key_s) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else if (i_tick) begin
          if (r_count == DEB_LAST) begin
            w_state_nxt = HELD;
            w_count_nxt = '0;
            w_press_nxt = 1'b1;
          end else begin
            w_count_nxt = w_count_inc;
          end
        end
      end
      HELD: begin
        if (i_key_s) begin
          w_state_nxt = DEB_REL;
          w_count_nxt = '0;
        end else if (i_tick) begin
          if (r_count == DELAY_LAST) begin
            w_state_nxt  = REPEATING;
            w_count_nxt  = '0;
            w_repeat_nxt = 1'b1;
          end else begin
            w_count_nxt = w_count_inc;
          end
        end
      end
      REPEATING: begin
        if (i_key_s) begin
          w_state_nxt = DEB_REL;
          w_count_nxt = '0;
        end else if (i_tick) begin
          if (r_count == RATE_LAST) begin
            w_count_nxt  = '0;
            w_repeat_nxt = 1'b1;
          end else begin
            w_count_nxt = w_count_inc;
          end
        end
      end
      DEB_REL: begin
        // A bounce back to pressed returns to HELD silently and restarts the
        // repeat delay from the beginning.
        if (!i_key_s) begin
          w_state_nxt = HELD;
          w_count_nxt = '0;
        end else if (i_tick) begin
          if (r_count == DEB_LAST) begin
            w_state_nxt   = IDLE;
            w_count_nxt   = '0;
            w_release_nxt = 1'b1;
          end else begin
            w_count_nxt = w_count_inc;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // The level reads released only while the press is not yet accepted.
  assign w_key_state_nxt = (w_state_nxt == IDLE) || (w_state_nxt == DEB_PRESS);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_key_state <= 1'b1;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_key_state <= w_key_state_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_repeat    <= w_repeat_nxt;
    end
  end

  assign o_key_state     = r_key_state;
  assign o_press_pulse   = r_press;
  assign o_release_pulse = r_release;
  assign o_repeat_pulse  = r_repeat;
  assign o_press_set     = w_press_nxt;
  assign o_repeat_set    = w_repeat_nxt;

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen
// Synchronises and debounces N_KEYS raw active-low keys on a shared tick and
// turns them into single-clk press / release / auto-repeat events plus a
// prioritised event code for the downstream frequency/display logic.
//
// Ports:
//   i_clk              system clock (F_CLK Hz)
//   i_rst_n            asynchronous active-low reset
//   i_key              raw keys, 0 = pressed, asynchronous to i_clk
//   o_key_state        debounced level per key, 0 = pressed
//   o_press_pulse      one-clk pulse per accepted press
//   o_release_pulse    one-clk pulse per accepted release
//   o_repeat_pulse     one-clk pulse per auto-repeat
//   o_evt_valid        one-clk pulse when any press or repeat bit is set
//   o_evt_code         lowest key index with a press/repeat; holds otherwise
//
// F_CLK / F_TICK must divide to an integer of at least 2; N_KEYS is 1..8.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int F_CLK              = 50000000,
  parameter int F_TICK             = 1000,
  parameter int N_KEYS             = 6,
  parameter int DEBOUNCE_TICKS     = 20,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_KEYS-1:0]    i_key,
  output logic [N_KEYS-1:0]    o_key_state,
  output logic [N_KEYS-1:0]    o_press_pulse,
  output logic [N_KEYS-1:0]    o_release_pulse,
  output logic [N_KEYS-1:0]    o_repeat_pulse,
  output logic                 o_evt_valid,
  output logic [KEY_IDX_W-1:0] o_evt_code
);

  localparam int TICK_DIV = F_CLK / F_TICK;
  localparam int TICK_W   = $clog2(TICK_DIV);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [N_KEYS-1:0]    r_sync1;
  logic [N_KEYS-1:0]    r_sync2;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic                 w_tick;
  logic [N_KEYS-1:0]    w_key_state;
  logic [N_KEYS-1:0]    w_press;
  logic [N_KEYS-1:0]    w_release;
  logic [N_KEYS-1:0]    w_repeat;
  logic [N_KEYS-1:0]    w_press_set;
  logic [N_KEYS-1:0]    w_repeat_set;
  logic [N_KEYS-1:0]    w_evt_set;
  logic                 w_evt_any;
  logic [KEY_IDX_W-1:0] w_evt_code_nxt;
  logic                 r_evt_valid;
  logic [KEY_IDX_W-1:0] r_evt_code;

  // Two-flop synchroniser; released (1) is the safe reset value so a key
  // held through reset is seen as a fresh falling edge afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    key_event_fsm #(
      .DEBOUNCE_TICKS     (DEBOUNCE_TICKS),
      .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
      .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
    ) u_fsm (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_key_s         (r_sync2[gi]),
      .i_tick          (w_tick),
      .o_key_state     (w_key_state[gi]),
      .o_press_pulse   (w_press[gi]),
      .o_release_pulse (w_release[gi]),
      .o_repeat_pulse  (w_repeat[gi]),
      .o_press_set     (w_press_set[gi]),
      .o_repeat_set    (w_repeat_set[gi])
    );
  end

  // Encode from the pre-register pulse values so the registered event lands
  // on the same clk as the registered pulse vectors.
  assign w_evt_set = w_press_set | w_repeat_set;
  assign w_evt_any = |w_evt_set;

  // Scanning from the top down leaves the lowest set index as the winner.
  always_comb begin
    w_evt_code_nxt = r_evt_code;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (w_evt_set[i]) begin
        w_evt_code_nxt = KEY_IDX_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_code  <= '0;
    end else begin
      r_evt_valid <= w_evt_any;
      r_evt_code  <= w_evt_code_nxt;
    end
  end

  assign o_key_state     = w_key_state;
  assign o_press_pulse   = w_press;
  assign o_release_pulse = w_release;
  assign o_repeat_pulse  = w_repeat;
  assign o_evt_valid     = r_evt_valid;
  assign o_evt_code      = r_evt_code;

endmodule
